// File: rtl/key_event_ctrl.sv
// Avalon-MM push-button controller: synchronizes and debounces active-low keys,
// captures press events, and exposes mask/edge/press-count registers plus an irq.
module key_event_ctrl #(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_n_i,
  input  logic [1:0]          address_i,
  input  logic                chipselect_i,
  input  logic                write_i,
  input  logic [31:0]         writedata_i,
  output logic [31:0]         readdata_o,
  output logic                irq_o
);

  typedef enum logic [1:0] {
    UP        = 2'd0,
    WAIT_DOWN = 2'd1,
    DOWN      = 2'd2,
    WAIT_UP   = 2'd3
  } keyState_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] syncMeta_q;
  logic [NUM_KEYS-1:0] syncOut_q;
  logic [NUM_KEYS-1:0] keyPressed;
  wire  [NUM_KEYS-1:0] pressPulse;
  wire  [NUM_KEYS-1:0] keyLevel;

  logic [NUM_KEYS-1:0] irqMask_q, irqMask_d;
  logic [NUM_KEYS-1:0] edgeCapture_q, edgeCapture_d;
  logic [7:0]          pressCount_q, pressCount_d;
  logic [31:0]         readdata_q, readdata_d;
  logic                irq_q, irq_d;

  logic                writeEn;
  logic                wrMask, wrEdge, wrCount;
  logic [NUM_KEYS-1:0] edgeClear;
  logic [3:0]          pressPop;
  logic [8:0]          countSum;
  logic                unusedWritedata;

  // Synchronizer resets to "released" so no phantom press appears after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      syncMeta_q <= '1;
      syncOut_q  <= '1;
    end else begin
      syncMeta_q <= key_n_i;
      syncOut_q  <= syncMeta_q;
    end
  end

  assign keyPressed = ~syncOut_q;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : gKey
    keyState_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse;
    logic             level;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= UP;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        UP: begin
          if (keyPressed[k]) begin
            state_d = WAIT_DOWN;
            cnt_d   = '0;
          end
        end
        WAIT_DOWN: begin
          if (!keyPressed[k])         state_d = UP;
          else if (cnt_q == CNT_LAST) state_d = DOWN;
          else                        cnt_d   = cnt_q + CNT_W'(1);
        end
        DOWN: begin
          if (!keyPressed[k]) begin
            state_d = WAIT_UP;
            cnt_d   = '0;
          end
        end
        WAIT_UP: begin
          if (keyPressed[k])          state_d = DOWN;
          else if (cnt_q == CNT_LAST) state_d = UP;
          else                        cnt_d   = cnt_q + CNT_W'(1);
        end
        default: state_d = UP;
      endcase
    end

    // A bounce on release returns to DOWN without a pulse, so only UP->DOWN counts.
    always_comb begin
      pulse = (state_q == WAIT_DOWN) && keyPressed[k] && (cnt_q == CNT_LAST);
      level = (state_q == DOWN) || (state_q == WAIT_UP);
    end

    assign pressPulse[k] = pulse;
    assign keyLevel[k]   = level;
  end

  assign writeEn         = chipselect_i & write_i;
  assign wrMask          = writeEn && (address_i == 2'd1);
  assign wrEdge          = writeEn && (address_i == 2'd2);
  assign wrCount         = writeEn && (address_i == 2'd3);
  assign edgeClear       = wrEdge ? writedata_i[NUM_KEYS-1:0] : '0;
  assign unusedWritedata = ^writedata_i[31:NUM_KEYS];

  always_comb begin
    pressPop = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      pressPop = pressPop + {3'b000, pressPulse[i]};
    end
  end

  assign countSum = {1'b0, pressCount_q} + {5'b00000, pressPop};

  // Set beats clear on the edge register; a count clear reloads with this cycle's presses.
  always_comb begin
    irqMask_d     = wrMask ? writedata_i[NUM_KEYS-1:0] : irqMask_q;
    edgeCapture_d = (edgeCapture_q & ~edgeClear) | pressPulse;
    if (wrCount)          pressCount_d = {4'b0000, pressPop};
    else if (countSum[8]) pressCount_d = 8'hFF;
    else                  pressCount_d = countSum[7:0];
    irq_d = |(edgeCapture_q & irqMask_q);
  end

  always_comb begin
    readdata_d = '0;
    case (address_i)
      2'd0:    readdata_d[NUM_KEYS-1:0] = keyLevel;
      2'd1:    readdata_d[NUM_KEYS-1:0] = irqMask_q;
      2'd2:    readdata_d[NUM_KEYS-1:0] = edgeCapture_q;
      default: readdata_d[7:0]          = pressCount_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqMask_q     <= '0;
      edgeCapture_q <= '0;
      pressCount_q  <= '0;
      readdata_q    <= '0;
      irq_q         <= 1'b0;
    end else begin
      irqMask_q     <= irqMask_d;
      edgeCapture_q <= edgeCapture_d;
      pressCount_q  <= pressCount_d;
      readdata_q    <= readdata_d;
      irq_q         <= irq_d;
    end
  end

  assign readdata_o = readdata_q;
  assign irq_o      = irq_q;

endmodule

// File: doc/key_event_ctrl.md
Name: key_event_ctrl

Overview:
Avalon-MM slave controller for the board push-buttons.
- Synchronizes and debounces NUM_KEYS raw active-low key inputs, one per-key state machine each.
- Captures debounced press events into an edge-capture register, with a maskable interrupt and a saturating press counter.
- Sits between the key pins and the Nios II bus and supplies clean key events to the game software.

Parameters:
- NUM_KEYS, 2, number of key inputs (1..8).
- DEBOUNCE_CYCLES, 500000, number of consecutive stable sampled cycles required to accept a level change (10 ms at 50 MHz). Must be at least 2.
- CNT_W, 20, width of each debounce counter. Requires 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset.
- key_n  in  NUM_KEYS  raw asynchronous key pins; 0 = pressed.
- address  in  2  register word address.
- chipselect  in  1  slave select.
- write  in  1  write strobe, qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt, active-high.

Behaviour:
- Reset: reset reset_n, asynchronous, active-low; clock clk. Reset clears all of the following:
  - readdata = 0, irq = 0, edge_capture = 0, irq_mask = 0, press_count = 0.
  - Synchronizer flops are set to 1 (released).
  - All FSMs go to UP, all counters go to 0.
- Input synchronizer:
  - Two-flop synchronizer per key, then inverted, so pressed = 1.
  - The raw value sampled at edge E is seen by the FSM at edge E+2.
- Per-key FSM, states UP, WAIT_DOWN, DOWN, WAIT_UP:
  - UP: pressed -> WAIT_DOWN, cnt = 0.
  - WAIT_DOWN: released -> UP. If cnt == DEBOUNCE_CYCLES-1 -> DOWN and emit a one-cycle press pulse. Otherwise cnt++.
  - DOWN: released -> WAIT_UP, cnt = 0.
  - WAIT_UP: pressed -> DOWN with no new press pulse. If cnt == DEBOUNCE_CYCLES-1 -> UP. Otherwise cnt++.
  - Debounced level = 1 in DOWN and WAIT_UP.
  - Latency: the FSM enters DOWN at E+2+DEBOUNCE_CYCLES; the DATA read value changes one clock later.
  - Any bounce shorter than DEBOUNCE_CYCLES produces no press pulse and no level change.
- Register map (word addresses):
  - 0 DATA, read-only: bits [NUM_KEYS-1:0] = debounced levels. Writes are ignored.
  - 1 IRQ_MASK, read/write: bits [NUM_KEYS-1:0]. Upper bits read 0.
  - 2 EDGE_CAPTURE, read / write-1-to-clear:
    - A bit is set by that key's press pulse.
    - If a press pulse and a W1C for the same bit land in the same cycle, set wins and the bit stays 1.
  - 3 PRESS_COUNT, read / write-any-to-clear:
    - 8-bit counter; increments by the popcount of this cycle's press pulses and saturates at 255.
    - A clear in the same cycle as press pulses loads popcount(pulses).
- Read timing:
  - readdata <= mux(address) every clock, independent of chipselect; read latency is 1 cycle.
  - Unused bits read 0. Reads have no side effects.
- Writes take effect at the clock edge where chipselect & write are both 1.
- irq = |(edge_capture & irq_mask), registered, so it asserts 1 clock after the capture bit or mask bit updates.
  - Clearing the captured bit or its mask bit deasserts irq 1 clock later.
- Simultaneous key presses are captured and counted independently.

Test Plan (DEBOUNCE_CYCLES = 4, NUM_KEYS = 2):
- Reset check: assert reset_n = 0 mid-count with key 0 held -> readdata = 0 and irq = 0 immediately; after release of reset, DATA = 0 until a fresh 4-cycle stable press.
- Clean press: key_n[0] = 0 held from edge E -> DATA reads 0x1 from edge E+7. EDGE_CAPTURE = 0x1. PRESS_COUNT = 1. irq stays 0 because mask = 0.
- Bounce rejection: key_n[1] toggles with low periods of 3 cycles for 20 cycles, then stays high -> DATA = 0, EDGE_CAPTURE = 0, PRESS_COUNT = 0.
- Interrupt path:
  - Write IRQ_MASK = 0x3, then press key 1 -> irq = 1 one clock after EDGE_CAPTURE bit 1 sets.
  - Write 0x2 to address 2 -> irq = 0 on the following clock.
- Set-wins collision: issue a W1C of 0x1 on the exact cycle key 0's press pulse fires -> EDGE_CAPTURE bit 0 remains 1.
- Counter behaviour:
  - 300 debounced presses on key 0 -> PRESS_COUNT = 255.
  - Both keys pressed on the same cycle after a clear -> PRESS_COUNT = 2.
  - Write to address 3 on the cycle a single press pulse fires -> PRESS_COUNT = 1.
